// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and the 10-bit XNOR LFSR step for lfsr_rand_arbiter
package lfsr_pkg;
  localparam int LFSR_W = 10;
  typedef logic [LFSR_W-1:0] lfsr_t;
  localparam lfsr_t LFSR_LOCKUP = 10'h3FF;
  localparam lfsr_t LFSR_SAFE = 10'h000;
  typedef enum logic {STIR, READY} arb_state_t;
  function automatic lfsr_t lfsr_next(input lfsr_t q);
    return (q == LFSR_LOCKUP) ? LFSR_SAFE : {~(q[0] ^ q[3]), q[LFSR_W-1:1]};
  endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: 10-bit XNOR LFSR register with seed load and lockup-safe stepping
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  load,
  input  lfsr_t din,
  output lfsr_t q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= LFSR_SAFE;
    else if (load) q <= (din == LFSR_LOCKUP) ? LFSR_SAFE : din;
    else if (en) q <= lfsr_next(q);
endmodule

// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: round-robin sharing of one LFSR, stirred STEPS cycles between grants
// Optional grant counter output grant_cnt when RAND_STATS_EN is defined.
module lfsr_rand_arbiter
  import lfsr_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int STEPS = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            seed_load,
  input  lfsr_t           seed_in,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output lfsr_t           rand_out,
  output logic            busy
`ifdef RAND_STATS_EN
  ,
  output logic [15:0]     grant_cnt
`endif
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(STEPS + 1);
  arb_state_t state;
  logic [CW-1:0] stir_cnt;
  logic [PW-1:0] rr_ptr, win;
  logic found, issue;
  lfsr_t q;
  lfsr_core u_core (
    .clk (clk),
    .reset(reset),
    .en  (state == STIR),
    .load(seed_load),
    .din (seed_in),
    .q   (q)
  );
  // search starts just after the last winner so every requester gets a turn
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[PW'((int'(rr_ptr) + i) % NREQ)]) begin
        win = PW'((int'(rr_ptr) + i) % NREQ);
        found = 1'b1;
      end
    end
  end
  assign issue = (state == READY) && found && !seed_load;
  assign busy = (state == STIR);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= STIR;
      stir_cnt <= '0;
      rr_ptr <= PW'(NREQ - 1);
      gnt <= '0;
      rand_out <= LFSR_SAFE;
    end else begin
      gnt <= '0;
      if (seed_load) begin
        state <= STIR;
        stir_cnt <= '0;
      end else if (state == STIR) begin
        stir_cnt <= (stir_cnt == CW'(STEPS - 1)) ? '0 : stir_cnt + 1'b1;
        if (stir_cnt == CW'(STEPS - 1)) state <= READY;
      end else if (issue) begin
        gnt <= NREQ'(1) << win;
        rand_out <= q;
        rr_ptr <= win;
        state <= STIR;
      end
    end
`ifdef RAND_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) grant_cnt <= '0;
    else if (seed_load) grant_cnt <= '0;
    else if (issue && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// tb_lfsr_rand_arbiter: scoreboard bench; expected grants queued by stimulus, popped by a negedge monitor
module tb_lfsr_rand_arbiter;
  typedef struct {logic [3:0] g; logic [9:0] r; int at;} exp_t;
  logic clk = 1'b0, reset = 1'b1, seed_load = 1'b0;
  logic [9:0] seed_in = '0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [9:0] rand_out;
  logic busy;
`ifdef RAND_STATS_EN
  logic [15:0] grant_cnt;
`endif
  int n_chk = 0, n_fail = 0, cyc_n = 0;
  exp_t sb[$];
  exp_t e;
  logic [9:0] tbl [10] = '{10'h200, 10'h300, 10'h380, 10'h3C0, 10'h3E0,
                           10'h3F0, 10'h3F8, 10'h1FC, 10'h0FE, 10'h07F};
  lfsr_rand_arbiter #(.NREQ(4), .STEPS(10)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .gnt(gnt), .rand_out(rand_out), .busy(busy)
`ifdef RAND_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [9:0] m_step(input logic [9:0] v);
    if (v == 10'h3FF) return 10'h000;
    return (v >> 1) | ((v[0] == v[3]) ? 10'h200 : 10'h000);
  endfunction
  function automatic logic [9:0] m_stir(input logic [9:0] v);
    logic [9:0] x;
    x = v;
    for (int i = 0; i < 10; i++) x = m_step(x);
    return x;
  endfunction
  always @(negedge clk)
    if (gnt !== 4'b0) begin
      if (sb.size() == 0) check("unexpected_gnt", 32'(gnt), 32'h0);
      else begin
        e = sb.pop_front();
        check("gnt", 32'(gnt), 32'(e.g));
        check("rand_out", 32'(rand_out), 32'(e.r));
        check("gnt_cycle", cyc_n, e.at);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [9:0] v;
    int w;
    #1 reset = 1'b0;
    repeat (2) cyc();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rand", 32'(rand_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_lfsr", 32'(dut.u_core.q), 32'h0);
    // first grant after reset: stir from 000 ends at 07F
    req = 4'b0001;
    reset = 1'b1;
    sb.push_back('{4'b0001, 10'h07F, cyc_n + 11});
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("stir_seq", 32'(dut.u_core.q), 32'(tbl[k]));
      check("stir_busy", 32'(busy), (k < 9) ? 32'h1 : 32'h0);
    end
    cyc();
    req = 4'b0000;
    cyc();
    check("gnt_one_cycle", 32'(gnt), 32'h0);
    check("rand_hold", 32'(rand_out), 32'h07F);
    // all four requesting: round-robin 0,1,2,3,0 every 11 cycles
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    req = 4'b1111;
    v = 10'h07F;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) v = m_stir(v);
      sb.push_back('{4'b0001 << (k % 4), v, cyc_n + 11 * (k + 1)});
    end
    repeat (55) cyc();
    req = 4'b0000;
`ifdef RAND_STATS_EN
    check("stats_cnt5", 32'(grant_cnt), 32'd5);
`endif
    // lockup seed 3FF is replaced by 000, so the next word is 07F again
    repeat (2) cyc();
    seed_in = 10'h3FF;
    seed_load = 1'b1;
    req = 4'b0001;
    sb.push_back('{4'b0001, 10'h07F, cyc_n + 12});
    cyc();
    seed_load = 1'b0;
    check("seed_lockup", 32'(dut.u_core.q), 32'h000);
`ifdef RAND_STATS_EN
    check("stats_clear", 32'(grant_cnt), 32'd0);
`endif
    repeat (11) cyc();
    req = 4'b0000;
`ifdef RAND_STATS_EN
    check("stats_cnt1", 32'(grant_cnt), 32'd1);
`endif
    // seed collides with a request in READY: seed wins, grant after new stir
    w = 0;
    while (busy && w < 40) begin
      cyc();
      w++;
    end
    check("ready_wait", 32'(busy), 32'h0);
    req = 4'b0001;
    seed_in = 10'h155;
    seed_load = 1'b1;
    sb.push_back('{4'b0001, 10'h280, cyc_n + 12});
    cyc();
    seed_load = 1'b0;
    check("seed_load_q", 32'(dut.u_core.q), 32'h155);
    check("seed_no_gnt", 32'(gnt), 32'h0);
    repeat (11) cyc();
    req = 4'b0000;
    // async reset at stir_cnt=5
    repeat (5) cyc();
    check("stir_cnt5", 32'(dut.stir_cnt), 32'd5);
    req = 4'b0001;
    #2 reset = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_lfsr", 32'(dut.u_core.q), 32'h000);
    check("async_busy", 32'(busy), 32'h1);
    check("async_rand", 32'(rand_out), 32'h000);
    cyc();
    reset = 1'b1;
    sb.push_back('{4'b0001, 10'h07F, cyc_n + 11});
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("restir_busy", 32'(busy), (k < 9) ? 32'h1 : 32'h0);
    end
    cyc();
    // reset during the grant cycle drops gnt at once
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("gnt_async_drop", 32'(gnt), 32'h0);
    req = 4'b0000;
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
Shares one 10-bit XNOR LFSR random source between NREQ requesters (game logic, computer-player, LED effects) under round-robin arbitration. After each grant the LFSR is stirred for STEPS cycles, so consecutive consumers never receive correlated words. Supports runtime seeding. Sits between the LFSR datapath and the modules consuming random values.

Parameters:
NREQ, 4, number of requesters (2..8)
STEPS, 10, LFSR advances between grants (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
seed_load  input  1  load seed_in into LFSR this cycle
seed_in  input  10  seed value
req  input  NREQ  request lines, level, held until own gnt
gnt  output  NREQ  one-hot one-cycle grant pulse
rand_out  output  10  random word, valid while any gnt bit high
busy  output  1  high in STIR state

Behaviour:
- Reset (reset=0, async): lfsr=10'h000, state=STIR, stir_cnt=0, rr_ptr=NREQ-1, gnt=0, rand_out=0, busy=1.
- LFSR step, when enabled: next = {~(q[0]^q[3]), q[9:1]}. Stepping occurs only in STIR; the LFSR holds in READY.
- STIR: step each cycle, stir_cnt++. When stir_cnt==STEPS-1 (final step this cycle): stir_cnt<=0, state<=READY.
- READY: if req==0, hold. Otherwise winner = first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ. Next cycle: gnt[winner]=1, rand_out=current lfsr value, rr_ptr=winner, state=STIR. Latency: 1 cycle from req sampled in READY to gnt.
- gnt is registered and lasts exactly one cycle. rand_out holds its last value after gnt drops. Requests arriving during STIR wait and are not lost.
- Requester dropping req before gnt: no grant is issued to it. A req still high on its gnt cycle is treated as a new request.
- seed_load (any state, highest priority): lfsr<=seed_in, state<=STIR, stir_cnt<=0, no grant issued from that cycle. seed_in==10'h3FF (XNOR lockup) is replaced by 10'h000.
- Lockup guard: if lfsr ever equals 10'h3FF, the next step loads 10'h000 instead.
- seed_load and READY-with-req in the same cycle: the seed wins. The request stays pending and is served after the stir.
- Async reset mid-stir or mid-grant: all state returns to reset values immediately. gnt drops in the same cycle.

Optional Feature:
RAND_STATS_EN. When defined: adds output grant_cnt[15:0], the total number of grants issued. It increments on each gnt pulse, saturates at 16'hFFFF, clears on reset and on seed_load. When undefined: the port and counter do not exist. Arbitration and timing are identical in both builds.

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=10
  - typedef logic [LFSR_W-1:0] lfsr_t
  - LFSR_LOCKUP=10'h3FF
  - LFSR_SAFE=10'h000
  - enum arb_state_t {STIR, READY}
  - function lfsr_next(lfsr_t) implementing the step plus lockup guard
- Sub-module lfsr_core: ports clk, reset, en, load, din, q. Holds the shift register. The arbiter owns the FSM, the round-robin pointer and the counters.

Test Plan:
- Reset, then req=4'b0001 held: busy=1 for 10 cycles, then gnt=4'b0001 for one cycle with rand_out=10'h07F. Stir sequence must be 200,300,380,3C0,3E0,3F0,3F8,1FC,0FE,07F.
- req=4'b1111 held continuously: gnt order 0,1,2,3,0, with 10 STIR cycles plus 1 grant cycle between grants. No requester is starved.
- seed_in=10'h3FF with seed_load=1: lfsr becomes 10'h000. The next grant again yields 10'h07F.
- seed_load pulsed on the same cycle req0 is seen in READY: no gnt that cycle. gnt[0] follows 11 cycles later with the value stirred from the new seed.
- reset driven low mid-STIR at stir_cnt=5: gnt=0 and lfsr=000 immediately. After release, a full 10-cycle stir runs.
- RAND_STATS_EN build: 3 grants make grant_cnt=3, and seed_load clears it to 0. The non-RAND_STATS_EN build compiles without the port.
